// File: rtl/seg7_scan_if.sv
// seg7_scan_if: bus bundle for the four-digit seven-segment scanner.
// The master side drives the word, load strobe and blank level.
// The slave side (seg7_scan) drives the anode, segment, dp and frame_done outputs.
interface seg7_scan_if;
    logic [15:0] value;
    logic        load;
    logic        blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    modport master (
        output value, load, blank,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  value, load, blank,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/seg7_scan.sv
// seg7_scan: four-digit multiplexed seven-segment driver.
// It double-buffers a 16-bit word through a shadow register and a display register.
// The display register is refreshed only at frame boundaries, so digits never tear.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN turns off leading-zero digits k>=1.
// The blanking decision is taken from the display register.
module seg7_scan #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic         clk,
    input  logic         reset,
    seg7_scan_if.slave   bus
);

    localparam int unsigned CNT_W = 20;
    localparam int unsigned IDX_W = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [15:0]      disp_q, disp_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             frame_done_q, frame_done_d;

    logic             tick;
    logic             wrap;
    logic [3:0]       nib;
    logic             lz_dark;

    // Hex nibble to active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Slot divider and digit index; a wrap is the tick that leaves digit 3
    always_comb begin
        tick  = (cnt_q == CNT_MAX);
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d = tick ? idx_q + IDX_W'(1) : idx_q;
        wrap  = tick && (idx_q == IDX_W'(3));
    end

    // Shadow takes every load; display takes the shadow at the boundary (load bypasses)
    always_comb begin
        shadow_d = bus.load ? bus.value : shadow_q;
        disp_d   = wrap ? shadow_d : disp_q;
    end

    // Output stage follows the next index so outputs move one clock after the tick
    always_comb begin
        nib     = 4'h0;
        lz_dark = 1'b0;
        case (idx_d)
            2'd0: nib = disp_d[3:0];
            2'd1: nib = disp_d[7:4];
            2'd2: nib = disp_d[11:8];
            default: nib = disp_d[15:12];
        endcase
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        case (idx_d)
            2'd1: lz_dark = (disp_d[15:4] == 12'h000);
            2'd2: lz_dark = (disp_d[15:8] == 8'h00);
            2'd3: lz_dark = (disp_d[15:12] == 4'h0);
            default: lz_dark = 1'b0;
        endcase
`endif
        an_d = ~(4'b0001 << idx_d);
        if (bus.blank || lz_dark) begin
            an_d = 4'hF;
        end
        seg_d        = hex_to_seg(nib);
        dp_d         = 1'b1;
        frame_done_d = wrap;
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            disp_q       <= '0;
            an_q         <= 4'hF;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            disp_q       <= disp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed and random stimulus checked against an edge-count model.
// The model derives the slot and frame position from the number of edges since reset.
// It keeps the shadow and display words as plain variables.
module tb_seg7_scan;

    localparam int unsigned DIV   = 4;
    localparam int unsigned FRAME = 4 * DIV;

    logic clk;
    logic reset;
    seg7_scan_if sif ();

    seg7_scan #(.REFRESH_DIV(DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          e      = 0;
    logic [15:0] sh_m   = 16'h0;
    logic [15:0] disp_m = 16'h0;
    logic [6:0]  hex_tab [16];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, e);
        end
    endtask

    // Compare all outputs with the model after edge e
    task automatic check_outputs();
        int          idx;
        logic [15:0] upper;
        logic [3:0]  an_exp;
        logic [3:0]  digit;
        idx    = (e / DIV) % 4;
        upper  = disp_m >> (4 * idx);
        digit  = upper[3:0];
        an_exp = ~(4'b0001 << idx);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (idx > 0 && upper == 16'h0) an_exp = 4'hF;
`endif
        if (sif.blank) an_exp = 4'hF;
        chk("an", {4'h0, sif.an}, {4'h0, an_exp});
        chk("seg", {1'b0, sif.seg}, {1'b0, hex_tab[digit]});
        chk("dp", {7'h0, sif.dp}, 8'h01);
        chk("frame_done", {7'h0, sif.frame_done}, {7'h0, (e % FRAME) == 0});
    endtask

    task automatic step(input logic ld, input logic [15:0] v, input logic bl);
        sif.load  = ld;
        sif.value = v;
        sif.blank = bl;
        @(posedge clk);
        e++;
        if (ld) sh_m = v;
        if ((e % FRAME) == 0) disp_m = sh_m;
        #1;
        check_outputs();
    endtask

    task automatic idle_to(input int target);
        while (e < target) step(1'b0, 16'h0, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_an"}, {4'h0, sif.an}, 8'h0F);
        chk({tag, "_seg"}, {1'b0, sif.seg}, 8'h7F);
        chk({tag, "_dp"}, {7'h0, sif.dp}, 8'h01);
        chk({tag, "_fd"}, {7'h0, sif.frame_done}, 8'h00);
    endtask

    initial begin
        hex_tab[0]  = 7'h40; hex_tab[1]  = 7'h79; hex_tab[2]  = 7'h24; hex_tab[3]  = 7'h30;
        hex_tab[4]  = 7'h19; hex_tab[5]  = 7'h12; hex_tab[6]  = 7'h02; hex_tab[7]  = 7'h78;
        hex_tab[8]  = 7'h00; hex_tab[9]  = 7'h10; hex_tab[10] = 7'h08; hex_tab[11] = 7'h03;
        hex_tab[12] = 7'h46; hex_tab[13] = 7'h21; hex_tab[14] = 7'h06; hex_tab[15] = 7'h0E;

        // Reset held: outputs at reset values
        reset     = 1'b1;
        sif.load  = 1'b0;
        sif.value = 16'h0;
        sif.blank = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;

        // First edge shows digit 0 of 0x0000, frame_done at edge 16
        idle_to(FRAME);

        // Scan order with 1A2F loaded just after the boundary
        step(1'b1, 16'h1A2F, 1'b0);
        idle_to(4 * FRAME);

        // Double buffering: two loads inside one frame, last one wins
        idle_to(4 * FRAME + 5);
        step(1'b1, 16'h1234, 1'b0);
        idle_to(4 * FRAME + 10);
        step(1'b1, 16'h5678, 1'b0);
        idle_to(7 * FRAME);

        // Boundary bypass: load on the wrap tick cycle
        idle_to(8 * FRAME - 1);
        step(1'b1, 16'hBEEF, 1'b0);
        idle_to(9 * FRAME + 3);

        // Blank for 10 cycles, then resume without re-sync
        for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b0);

        // Random loads, values and blanking
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 7) == 0), 16'($urandom), ($urandom_range(0, 5) == 0));
        end

        // Pending load then asynchronous reset mid-slot
        step(1'b1, 16'h9C3D, 1'b0);
        step(1'b0, 16'h0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        check_reset_state("async_reset");
        @(negedge clk);
        reset  = 1'b0;
        e      = 0;
        sh_m   = 16'h0;
        disp_m = 16'h0;
        idle_to(FRAME + 2);

        // Leading-zero candidate value
        step(1'b1, 16'h0050, 1'b0);
        idle_to(4 * FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
